dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12: byte-address bits decoded; memory depth is 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter INIT_ZERO, default 1: 1 = memory array initialised to zero at elaboration; 0 = no initialisation.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 funct  input  3  access size: 000 byte, 001 half, 010 word, 100 byte unsigned (load only), 101 half unsigned (load only).
REQ-009 addr  input  32  byte address; bits above ADDR_W-1 ignored (aliasing).
REQ-010 w_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  one-cycle pulse completing the accepted request.
REQ-012 read_data  output  32  load result, valid when rsp_valid=1 and request was a load.
REQ-013 rsp_err  output  1  misalignment error flag, valid with rsp_valid.

Function
REQ-014 Request accepted on a rising edge where req_valid=1 and req_ready=1; addr, funct, w_data, req_we captured at acceptance.
REQ-015 FSM states IDLE, LOAD, RMW_RD, RMW_WR, RESP; req_ready=1 only in IDLE; one request in flight maximum.
REQ-016 Load: IDLE->LOAD->RESP; accepted at edge T, rsp_valid=1 during cycle T+2 with read_data registered.
REQ-017 Word store: IDLE->RESP; memory written at edge T, rsp_valid=1 during cycle T+1.
REQ-018 Byte/half store: IDLE->RMW_RD->RMW_WR->RESP; word read at T, merged word written at T+2 edge, rsp_valid=1 during cycle T+3.
REQ-019 Merge: only the addressed lane(s) replaced; byte lane = addr[1:0], half lane = addr[1]; other bytes preserved.
REQ-020 Load extraction: byte from lane addr[1:0], half from lane addr[1], shifted to bit 0; funct 000/001 sign-extend, 100/101 zero-extend.
REQ-021 Load with funct 011/110/111: read_data=0, rsp_err=0, rsp_valid per REQ-016.
REQ-022 Store with funct other than 000/001/010: no memory write, IDLE->RESP, rsp_valid during cycle T+1.
REQ-023 RESP->IDLE unconditionally after one cycle; rsp_valid never asserted in two consecutive cycles.
REQ-024 read_data holds its last value between responses; after a store response it is unchanged.
REQ-025 req_valid while req_ready=0 ignored; requester holds request until accepted.

Reset
REQ-026 reset low: FSM to IDLE immediately; req_ready=1, rsp_valid=0, rsp_err=0, read_data=0.
REQ-027 Reset during RMW_RD/RMW_WR/LOAD: request abandoned, no write performed after reset assertion, no rsp_valid issued.
REQ-028 Memory contents not cleared by reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN.
REQ-030 Defined: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned; no memory write, IDLE->RESP, rsp_valid during T+1 with rsp_err=1, read_data=0.
REQ-031 Not defined: rsp_err tied 0; misaligned half ignores addr[0], misaligned word ignores addr[1:0]; timing per REQ-016..018.

Verification
REQ-032 Reset, SW 0x11223344 @0x100, LW @0x100 -> rsp_valid at T+2, read_data=0x11223344, rsp_err=0.
REQ-033 After REQ-032, SB 0xAB @0x102, LW @0x100 -> 0x11AB3344; store ack at T+3 of SB.
REQ-034 SW 0x8000FF80 @0x40; LB @0x40 -> 0xFFFFFF80; LBU @0x40 -> 0x00000080; LH @0x42 -> 0xFFFF8000; LHU @0x42 -> 0x00008000.
REQ-035 Assert reset in RMW_WR of SH 0xBEEF @0x10 (word pre-set 0x12345678) -> no rsp_valid, LW @0x10 after release -> 0x12345678.
REQ-036 With DMEM_MISALIGN_TRAP_EN: LW @0x101 -> rsp_valid at T+1, rsp_err=1, read_data=0; SH @0x103 leaves memory unchanged; without macro LW @0x101 returns word @0x100, rsp_err=0.
REQ-037 req_valid held high over back-to-back loads -> req_ready low in LOAD/RESP, second request accepted the cycle after RESP, one rsp_valid per request.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores, with read-modify-write for sub-word stores.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  funct,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic        rsp_valid,
    output logic [31:0] read_data,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [31:0]        r_read_data;
    logic [31:0]        r_rd_word;
    logic [31:0]        r_wr_word;
    logic [15:0]        r_wdata;
    logic [2:0]         r_funct;
    logic [1:0]         r_lane;
    logic [IDX_W-1:0]   r_idx;

    logic               w_accept;
    logic               w_misalign;
    logic               w_trap;
    logic [IDX_W-1:0]   w_idx_in;
    logic               w_mem_we;
    logic [IDX_W-1:0]   w_mem_idx;
    logic [31:0]        w_mem_wdata;
    logic [31:0]        w_mem_rd;
    logic [31:0]        w_merged;
    logic [31:0]        w_load_val;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_unused;

    // No acceptance while reset is held, so nothing reaches the array during reset.
    assign w_accept = req_valid & r_req_ready & reset;
    assign w_idx_in = addr[ADDR_W-1:2];
    assign w_unused = ^addr[31:ADDR_W];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (((funct == 3'b001) || (funct == 3'b101)) && addr[0])
                      || ((funct == 3'b010) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory write control
    always_comb begin
        w_state_nxt = r_state;
        w_trap      = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_idx   = r_idx;
        w_mem_wdata = r_wr_word;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_state_nxt = RESP;
                        w_trap      = 1'b1;
                    end else if (!req_we) begin
                        w_state_nxt = LOAD;
                    end else if (funct == 3'b010) begin
                        w_state_nxt = RESP;
                        w_mem_we    = 1'b1;
                        w_mem_idx   = w_idx_in;
                        w_mem_wdata = w_data;
                    end else if ((funct == 3'b000) || (funct == 3'b001)) begin
                        w_state_nxt = RMW_RD;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            LOAD:    w_state_nxt = RESP;
            RMW_RD:  w_state_nxt = RMW_WR;
            RMW_WR: begin
                w_state_nxt = RESP;
                w_mem_we    = reset;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered handshake and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_read_data <= 32'h0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_rsp_err   <= w_trap;
            if (r_state == LOAD) begin
                r_read_data <= w_load_val;
            end else if (w_trap) begin
                r_read_data <= 32'h0;
            end
        end
    end

    // Request capture and merge staging
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_word <= 32'h0;
            r_wr_word <= 32'h0;
            r_wdata   <= 16'h0;
            r_funct   <= 3'b000;
            r_lane    <= 2'b00;
            r_idx     <= '0;
        end else begin
            if (w_accept) begin
                r_rd_word <= w_mem_rd;
                r_wdata   <= w_data[15:0];
                r_funct   <= funct;
                r_lane    <= addr[1:0];
                r_idx     <= w_idx_in;
            end
            if (r_state == RMW_RD) begin
                r_wr_word <= w_merged;
            end
        end
    end

    assign w_byte = r_rd_word[{r_lane, 3'b000} +: 8];
    assign w_half = r_rd_word[{r_lane[1], 4'b0000} +: 16];

    // Sub-word merge: only the addressed lane changes
    always_comb begin
        w_merged = r_rd_word;
        if (r_funct == 3'b000) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_funct == 3'b001) begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    // Load extraction with sign/zero extension
    always_comb begin
        w_load_val = 32'h0;
        case (r_funct)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_val = r_rd_word;
            3'b100:  w_load_val = {24'h0, w_byte};
            3'b101:  w_load_val = {16'h0, w_half};
            default: w_load_val = 32'h0;
        endcase
    end

    generate
        if (INIT_ZERO != 0) begin : g_mem_zero
            logic [31:0] r_mem [DEPTH] = '{default: 32'h0};
            always_ff @(posedge clk) begin
                if (w_mem_we) begin
                    r_mem[w_mem_idx] <= w_mem_wdata;
                end
            end
            assign w_mem_rd = r_mem[w_idx_in];
        end else begin : g_mem_raw
            logic [31:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (w_mem_we) begin
                    r_mem[w_mem_idx] <= w_mem_wdata;
                end
            end
            assign w_mem_rd = r_mem[w_idx_in];
        end
    endgenerate

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign read_data = r_read_data;
    assign rsp_err   = r_rsp_err;

endmodule
